// File: rtl/sat_pkg.sv
// Shared SAT-engine types: variable index width, trace entry kind and trace controller states.
// No logic here; every consumer imports this package.
package sat_pkg;

    localparam int VAR_W = 9;

    typedef enum logic {
        T_DECISION = 1'b0,
        T_FORCED   = 1'b1
    } trace_type_e;

    typedef enum logic [2:0] {
        IDLE,
        PUSH_WAIT,
        POP_REQ,
        POP_WAIT,
        UNASSIGN,
        FLIP_PUSH,
        FLIP_WAIT,
        UNSAT
    } tc_state_e;

endpackage

// File: rtl/trace_ctrl_if.sv
// Bundle between the trace controller and its neighbours (BCP, decider, trace table, assignment store).
// master = controller side, slave = environment side.
interface trace_ctrl_if #(
    parameter int VAR_W = 9,
    parameter int LVL_W = 8
);
    logic             imp_req;
    logic [VAR_W-1:0] imp_var;
    logic             imp_val;
    logic             imp_gnt;
    logic             dec_req;
    logic [VAR_W-1:0] dec_var;
    logic             dec_val;
    logic             dec_gnt;
    logic             conflict;
    logic             tt_push;
    logic             tt_pop;
    logic             tt_type;
    logic             tt_val;
    logic [VAR_W-1:0] tt_var;
    logic             tt_type_in;
    logic             tt_val_in;
    logic [VAR_W-1:0] tt_var_in;
    logic             tt_empty;
    logic             tt_done;
    logic             unassign_valid;
    logic [VAR_W-1:0] unassign_var;
    logic [LVL_W-1:0] level;
    logic             busy;
    logic             bt_done;
    logic             unsat;

    modport master (
        input  imp_req, imp_var, imp_val, dec_req, dec_var, dec_val, conflict,
               tt_type_in, tt_val_in, tt_var_in, tt_empty, tt_done,
        output imp_gnt, dec_gnt, tt_push, tt_pop, tt_type, tt_val, tt_var,
               unassign_valid, unassign_var, level, busy, bt_done, unsat
    );

    modport slave (
        output imp_req, imp_var, imp_val, dec_req, dec_var, dec_val, conflict,
               tt_type_in, tt_val_in, tt_var_in, tt_empty, tt_done,
        input  imp_gnt, dec_gnt, tt_push, tt_pop, tt_type, tt_val, tt_var,
               unassign_valid, unassign_var, level, busy, bt_done, unsat
    );

endinterface

// File: rtl/trace_ctrl_push_arb.sv
// Fixed-priority push arbiter: implication beats decision, payload follows the winner.
// Zero latency, combinational; grants only when i_en is high.
module push_arb #(
    parameter int VAR_W = 9
) (
    input  logic             i_en,
    input  logic             i_imp_req,
    input  logic [VAR_W-1:0] i_imp_var,
    input  logic             i_imp_val,
    input  logic             i_dec_req,
    input  logic [VAR_W-1:0] i_dec_var,
    input  logic             i_dec_val,
    output logic             o_imp_gnt,
    output logic             o_dec_gnt,
    output logic             o_push,
    output logic             o_type,
    output logic [VAR_W-1:0] o_var,
    output logic             o_val
);
    import sat_pkg::*;

    logic w_imp;
    logic w_dec;

    assign w_imp     = i_en & i_imp_req;
    assign w_dec     = i_en & i_dec_req & ~i_imp_req;
    assign o_imp_gnt = w_imp;
    assign o_dec_gnt = w_dec;
    assign o_push    = w_imp | w_dec;

    always_comb begin
        o_type = T_DECISION;
        o_var  = '0;
        o_val  = 1'b0;
        if (w_imp) begin
            o_type = T_FORCED;
            o_var  = i_imp_var;
            o_val  = i_imp_val;
        end else if (w_dec) begin
            o_type = T_DECISION;
            o_var  = i_dec_var;
            o_val  = i_dec_val;
        end
    end

endmodule

// File: rtl/trace_ctrl.sv
// Trace controller: serialises BCP/decider pushes into the trace table and runs chronological backtrack.
// Commands issue in the cycle a state is entered; waits on tt_done, requests stall (no grant) while busy.
module trace_ctrl #(
    parameter int NUM_VARIABLE = 128,
    parameter int VAR_W        = sat_pkg::VAR_W
) (
    input  logic        clk,
    input  logic        reset,
    trace_ctrl_if.master bus
);
    import sat_pkg::*;

    localparam int               LVL_W   = $clog2(NUM_VARIABLE + 1);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(NUM_VARIABLE);

    tc_state_e        r_state, w_state_nxt;
    logic             r_pend, w_pend_nxt;
    logic [LVL_W-1:0] r_level, w_level_nxt;
    logic [VAR_W-1:0] r_cap_var;
    logic             r_cap_val;
    trace_type_e      r_cap_type;
    logic             w_cap_en;

    logic             w_arb_en;
    logic             w_imp_gnt, w_dec_gnt, w_arb_push, w_arb_type, w_arb_val;
    logic [VAR_W-1:0] w_arb_var;

    // Gating on reset keeps the Mealy grant path quiet while reset is held.
    assign w_arb_en = reset & (r_state == IDLE) & ~r_pend & ~bus.conflict;

    push_arb #(.VAR_W(VAR_W)) u_arb (
        .i_en      (w_arb_en),
        .i_imp_req (bus.imp_req),
        .i_imp_var (bus.imp_var),
        .i_imp_val (bus.imp_val),
        .i_dec_req (bus.dec_req),
        .i_dec_var (bus.dec_var),
        .i_dec_val (bus.dec_val),
        .o_imp_gnt (w_imp_gnt),
        .o_dec_gnt (w_dec_gnt),
        .o_push    (w_arb_push),
        .o_type    (w_arb_type),
        .o_var     (w_arb_var),
        .o_val     (w_arb_val)
    );

    assign bus.imp_gnt = w_imp_gnt;
    assign bus.dec_gnt = w_dec_gnt;
    assign bus.level   = r_level;
    assign bus.busy    = ~((r_state == IDLE) & ~r_pend);
    assign bus.unsat   = (r_state == UNSAT);

    always_comb begin
        w_state_nxt        = r_state;
        w_pend_nxt         = r_pend;
        w_level_nxt        = r_level;
        w_cap_en           = 1'b0;
        bus.tt_push        = 1'b0;
        bus.tt_pop         = 1'b0;
        bus.tt_type        = 1'b0;
        bus.tt_val         = 1'b0;
        bus.tt_var         = '0;
        bus.unassign_valid = 1'b0;
        bus.unassign_var   = '0;
        bus.bt_done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.conflict || r_pend) begin
                    w_pend_nxt  = 1'b0;
                    w_state_nxt = POP_REQ;
                end else if (w_arb_push) begin
                    bus.tt_push = 1'b1;
                    bus.tt_type = w_arb_type;
                    bus.tt_var  = w_arb_var;
                    bus.tt_val  = w_arb_val;
                    if (w_dec_gnt && (r_level != LVL_MAX))
                        w_level_nxt = r_level + LVL_W'(1);
                    w_state_nxt = PUSH_WAIT;
                end
            end
            PUSH_WAIT: begin
                if (bus.conflict)
                    w_pend_nxt = 1'b1;
                if (bus.tt_done)
                    w_state_nxt = IDLE;
            end
            POP_REQ: begin
                bus.tt_pop  = 1'b1;
                w_state_nxt = POP_WAIT;
            end
            POP_WAIT: begin
                if (bus.tt_done) begin
                    if (bus.tt_empty) begin
                        w_state_nxt = UNSAT;
                    end else begin
                        w_cap_en    = 1'b1;
                        w_state_nxt = UNASSIGN;
                    end
                end
            end
            UNASSIGN: begin
                bus.unassign_valid = 1'b1;
                bus.unassign_var   = r_cap_var;
                if (r_cap_type == T_FORCED) begin
                    w_state_nxt = POP_REQ;
                end else begin
                    if (r_level != '0)
                        w_level_nxt = r_level - LVL_W'(1);
                    w_state_nxt = FLIP_PUSH;
                end
            end
            FLIP_PUSH: begin
                // The flipped decision goes back as forced: it is now implied by the learnt conflict.
                bus.tt_push = 1'b1;
                bus.tt_type = T_FORCED;
                bus.tt_var  = r_cap_var;
                bus.tt_val  = ~r_cap_val;
                w_state_nxt = FLIP_WAIT;
            end
            FLIP_WAIT: begin
                if (bus.tt_done) begin
                    bus.bt_done = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            UNSAT: w_state_nxt = UNSAT;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_pend     <= 1'b0;
            r_level    <= '0;
            r_cap_var  <= '0;
            r_cap_val  <= 1'b0;
            r_cap_type <= T_DECISION;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_level <= w_level_nxt;
            if (w_cap_en) begin
                r_cap_var  <= bus.tt_var_in;
                r_cap_val  <= bus.tt_val_in;
                r_cap_type <= trace_type_e'(bus.tt_type_in);
            end
        end
    end

endmodule

// File: tb/tb_trace_ctrl.sv
// Directed bench for trace_ctrl; the bench plays BCP, decider and trace table by hand.
module tb_trace_ctrl;
    import sat_pkg::*;

    localparam int NV = 128;
    localparam int VW = 9;
    localparam int LW = $clog2(NV + 1);

    logic clk;
    logic reset;
    int   n_vec  = 0;
    int   n_miss = 0;

    trace_ctrl_if #(.VAR_W(VW), .LVL_W(LW)) bus ();

    trace_ctrl #(.NUM_VARIABLE(NV), .VAR_W(VW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clr_in();
        bus.imp_req    = 1'b0;
        bus.imp_var    = '0;
        bus.imp_val    = 1'b0;
        bus.dec_req    = 1'b0;
        bus.dec_var    = '0;
        bus.dec_val    = 1'b0;
        bus.conflict   = 1'b0;
        bus.tt_type_in = 1'b0;
        bus.tt_val_in  = 1'b0;
        bus.tt_var_in  = '0;
        bus.tt_empty   = 1'b0;
        bus.tt_done    = 1'b0;
    endtask

    task automatic done_pulse();
        bus.tt_done = 1'b1;
        tick();
        bus.tt_done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic push_dec(input logic [VW-1:0] v, input logic val);
        bus.dec_req = 1'b1;
        bus.dec_var = v;
        bus.dec_val = val;
        settle();
        chk_vec("dec_gnt", 32'(bus.dec_gnt), 1);
        tick();
        bus.dec_req = 1'b0;
        done_pulse();
    endtask

    task automatic push_imp(input logic [VW-1:0] v, input logic val);
        bus.imp_req = 1'b1;
        bus.imp_var = v;
        bus.imp_val = val;
        settle();
        chk_vec("imp_gnt", 32'(bus.imp_gnt), 1);
        tick();
        bus.imp_req = 1'b0;
        done_pulse();
    endtask

    // Entered in POP_REQ; leaves in the cycle after UNASSIGN.
    task automatic pop_step(input logic typ, input logic [VW-1:0] v, input logic val);
        settle();
        chk_vec("tt_pop", 32'(bus.tt_pop), 1);
        tick();
        bus.tt_done    = 1'b1;
        bus.tt_empty   = 1'b0;
        bus.tt_type_in = typ;
        bus.tt_var_in  = v;
        bus.tt_val_in  = val;
        tick();
        bus.tt_done    = 1'b0;
        bus.tt_type_in = 1'b0;
        bus.tt_var_in  = '0;
        bus.tt_val_in  = 1'b0;
        settle();
        chk_vec("unassign_valid", 32'(bus.unassign_valid), 1);
        chk_vec("unassign_var", 32'(bus.unassign_var), 32'(v));
        tick();
    endtask

    initial begin
        clr_in();
        reset = 1'b0;
        #3;
        chk_vec("rst busy", 32'(bus.busy), 0);
        chk_vec("rst level", 32'(bus.level), 0);
        chk_vec("rst unsat", 32'(bus.unsat), 0);
        chk_vec("rst tt_push", 32'(bus.tt_push), 0);
        chk_vec("rst tt_pop", 32'(bus.tt_pop), 0);
        chk_vec("rst bt_done", 32'(bus.bt_done), 0);
        tick();
        tick();
        reset = 1'b1;

        // Simultaneous requests: implication first, then the decision.
        bus.imp_req = 1'b1; bus.imp_var = 9'd5; bus.imp_val = 1'b1;
        bus.dec_req = 1'b1; bus.dec_var = 9'd9; bus.dec_val = 1'b0;
        settle();
        chk_vec("A imp_gnt", 32'(bus.imp_gnt), 1);
        chk_vec("A dec_gnt lose", 32'(bus.dec_gnt), 0);
        chk_vec("A tt_push", 32'(bus.tt_push), 1);
        chk_vec("A tt_type", 32'(bus.tt_type), 1);
        chk_vec("A tt_var", 32'(bus.tt_var), 5);
        chk_vec("A tt_val", 32'(bus.tt_val), 1);
        tick();
        bus.imp_req = 1'b0;
        settle();
        chk_vec("A wait busy", 32'(bus.busy), 1);
        chk_vec("A wait no gnt", 32'(bus.dec_gnt), 0);
        chk_vec("A wait no push", 32'(bus.tt_push), 0);
        done_pulse();
        settle();
        chk_vec("A dec_gnt", 32'(bus.dec_gnt), 1);
        chk_vec("A dec type", 32'(bus.tt_type), 0);
        chk_vec("A dec var", 32'(bus.tt_var), 9);
        chk_vec("A dec val", 32'(bus.tt_val), 0);
        chk_vec("A level pre", 32'(bus.level), 0);
        tick();
        bus.dec_req = 1'b0;
        settle();
        chk_vec("A level post", 32'(bus.level), 1);
        done_pulse();
        do_reset();
        settle();
        chk_vec("A level reset", 32'(bus.level), 0);

        // Backtrack through two forced entries to the decision var3.
        push_dec(9'd3, 1'b1);
        push_imp(9'd7, 1'b0);
        push_imp(9'd8, 1'b1);
        chk_vec("B level", 32'(bus.level), 1);
        bus.conflict = 1'b1;
        bus.dec_req = 1'b1; bus.dec_var = 9'd2;
        settle();
        chk_vec("B conflict beats dec", 32'(bus.dec_gnt), 0);
        chk_vec("B conflict no push", 32'(bus.tt_push), 0);
        tick();
        bus.conflict = 1'b0;
        bus.dec_req = 1'b0;
        pop_step(1'b1, 9'd8, 1'b1);
        pop_step(1'b1, 9'd7, 1'b0);
        pop_step(1'b0, 9'd3, 1'b1);
        settle();
        chk_vec("B level dec", 32'(bus.level), 0);
        chk_vec("B flip push", 32'(bus.tt_push), 1);
        chk_vec("B flip type", 32'(bus.tt_type), 1);
        chk_vec("B flip var", 32'(bus.tt_var), 3);
        chk_vec("B flip val", 32'(bus.tt_val), 0);
        tick();
        settle();
        chk_vec("B bt_done early", 32'(bus.bt_done), 0);
        bus.tt_done = 1'b1;
        settle();
        chk_vec("B bt_done", 32'(bus.bt_done), 1);
        tick();
        bus.tt_done = 1'b0;
        settle();
        chk_vec("B bt_done clear", 32'(bus.bt_done), 0);
        chk_vec("B idle busy", 32'(bus.busy), 0);

        // Conflict during PUSH_WAIT is held and beats the waiting decision.
        bus.dec_req = 1'b1; bus.dec_var = 9'd4; bus.dec_val = 1'b1;
        settle();
        tick();
        bus.conflict = 1'b1;
        tick();
        bus.conflict = 1'b0;
        bus.tt_done = 1'b1;
        tick();
        bus.tt_done = 1'b0;
        settle();
        chk_vec("C pending no gnt", 32'(bus.dec_gnt), 0);
        chk_vec("C pending no push", 32'(bus.tt_push), 0);
        chk_vec("C pending busy", 32'(bus.busy), 1);
        tick();
        bus.dec_req = 1'b0;
        pop_step(1'b0, 9'd4, 1'b1);
        settle();
        chk_vec("C level", 32'(bus.level), 0);
        chk_vec("C flip var", 32'(bus.tt_var), 4);
        chk_vec("C flip val", 32'(bus.tt_val), 0);
        tick();
        bus.tt_done = 1'b1;
        settle();
        chk_vec("C bt_done", 32'(bus.bt_done), 1);
        tick();
        bus.tt_done = 1'b0;

        // Asynchronous reset while in POP_WAIT.
        push_dec(9'd6, 1'b0);
        chk_vec("D level", 32'(bus.level), 1);
        bus.conflict = 1'b1;
        tick();
        bus.conflict = 1'b0;
        tick();
        bus.imp_req = 1'b1; bus.imp_var = 9'd1; bus.imp_val = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk_vec("D async level", 32'(bus.level), 0);
        chk_vec("D async busy", 32'(bus.busy), 0);
        chk_vec("D async imp_gnt", 32'(bus.imp_gnt), 0);
        chk_vec("D async tt_push", 32'(bus.tt_push), 0);
        chk_vec("D async unassign", 32'(bus.unassign_valid), 0);
        tick();
        tick();
        reset = 1'b1;
        settle();
        chk_vec("D idle imp_gnt", 32'(bus.imp_gnt), 1);
        tick();
        bus.imp_req = 1'b0;
        done_pulse();

        // Empty trace on conflict: sticky UNSAT.
        do_reset();
        bus.conflict = 1'b1;
        tick();
        bus.conflict = 1'b0;
        settle();
        chk_vec("E tt_pop", 32'(bus.tt_pop), 1);
        tick();
        bus.tt_done = 1'b1;
        bus.tt_empty = 1'b1;
        tick();
        bus.tt_done = 1'b0;
        bus.tt_empty = 1'b0;
        bus.dec_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.tt_done = (i == 1);
            settle();
            chk_vec("E unsat", 32'(bus.unsat), 1);
            chk_vec("E busy", 32'(bus.busy), 1);
            chk_vec("E no dec_gnt", 32'(bus.dec_gnt), 0);
            chk_vec("E no pop", 32'(bus.tt_pop), 0);
            tick();
        end
        clr_in();
        do_reset();
        settle();
        chk_vec("E unsat cleared", 32'(bus.unsat), 0);

        // Level floor: decision popped at level 0 stays at 0.
        bus.conflict = 1'b1;
        tick();
        bus.conflict = 1'b0;
        pop_step(1'b0, 9'd11, 1'b0);
        settle();
        chk_vec("F level floor", 32'(bus.level), 0);
        tick();
        done_pulse();

        // Level ceiling.
        for (int i = 0; i < NV; i++) push_dec(VW'(i), 1'(i));
        chk_vec("G level max", 32'(bus.level), 128);
        bus.dec_req = 1'b1; bus.dec_var = 9'd200; bus.dec_val = 1'b1;
        settle();
        chk_vec("G extra gnt", 32'(bus.dec_gnt), 1);
        tick();
        bus.dec_req = 1'b0;
        settle();
        chk_vec("G level sat", 32'(bus.level), 128);
        done_pulse();
        bus.conflict = 1'b1;
        tick();
        bus.conflict = 1'b0;
        pop_step(1'b0, 9'd200, 1'b1);
        settle();
        chk_vec("G level 127", 32'(bus.level), 127);
        tick();
        done_pulse();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/trace_ctrl.md
TRACE_CTRL -- requirements
Module: trace_ctrl

Interface
REQ-001 Parameter NUM_VARIABLE, default 128, max trace depth / variable count.
REQ-002 Parameter VAR_W, default 9, variable index width.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-low (0 = reset).
REQ-005 imp_req/imp_var/imp_val  in  1/VAR_W/1  implication push request from BCP; imp_gnt out 1 acceptance pulse.
REQ-006 dec_req/dec_var/dec_val  in  1/VAR_W/1  decision push request from decider; dec_gnt out 1 acceptance pulse.
REQ-007 conflict  in  1  single-cycle pulse requesting backtrack.
REQ-008 tt_push, tt_pop  out  1  one-cycle command pulses to trace table.
REQ-009 tt_type, tt_val, tt_var  out  1/1/VAR_W  push payload (type 0 = decision D, 1 = forced F).
REQ-010 tt_type_in, tt_val_in, tt_var_in, tt_empty, tt_done  in  1/1/VAR_W/1/1  trace-table pop result and completion strobe.
REQ-011 unassign_valid, unassign_var  out  1/VAR_W  one-cycle command clearing a variable in the assignment store.
REQ-012 level  out  $clog2(NUM_VARIABLE+1)  current decision level.
REQ-013 busy, bt_done, unsat  out  1  controller active; backtrack-complete pulse; sticky unsatisfiable flag.

Function
REQ-014 States: IDLE, PUSH_WAIT, POP_REQ, POP_WAIT, UNASSIGN, FLIP_PUSH, FLIP_WAIT, UNSAT.
REQ-015 IDLE priority: conflict > imp_req > dec_req; a granting cycle asserts exactly one of imp_gnt/dec_gnt and tt_push with payload (imp: type 1; dec: type 0), then -> PUSH_WAIT.
REQ-016 PUSH_WAIT: no new command issued; on tt_done -> IDLE; dec push increments level in the tt_push cycle.
REQ-017 Conflict arriving outside IDLE/PUSH_WAIT ignored; in PUSH_WAIT latched (pending) and serviced on return to IDLE, ahead of requests.
REQ-018 Backtrack: POP_REQ pulses tt_pop one cycle -> POP_WAIT; on tt_done with tt_empty=1 -> UNSAT; else capture popped entry -> UNASSIGN.
REQ-019 UNASSIGN: unassign_valid=1, unassign_var=captured var for one cycle; captured type 1 -> POP_REQ; type 0 -> level decrements, -> FLIP_PUSH.
REQ-020 FLIP_PUSH: tt_push with type 1, val = ~captured val, same var -> FLIP_WAIT; on tt_done pulse bt_done one cycle -> IDLE.
REQ-021 UNSAT: unsat=1, busy=1, no grants or commands until reset.
REQ-022 busy=0 only in IDLE with no pending conflict; grants never asserted while busy.
REQ-023 level saturates: no increment at NUM_VARIABLE, no decrement at 0.
REQ-024 tt_done arriving in any state other than PUSH_WAIT/POP_WAIT/FLIP_WAIT ignored.
REQ-025 Push/pop latency: command pulse one cycle after grant decision is not allowed; command issued in same cycle as state entry action.

Reset
REQ-026 reset=0 forces asynchronously: state IDLE, level 0, pending conflict 0, unsat 0, all pulses/gnts/tt_push/tt_pop/unassign_valid/bt_done 0, busy 0, captured/payload registers 0.
REQ-027 Reset mid-backtrack abandons sequence; trace table reset concurrently by system.

Structure
REQ-028 Shared package sat_pkg holds VAR_W, trace type enum (T_DECISION=0, T_FORCED=1), and trace_ctrl state enum.
REQ-029 One sub-module push_arb: combinational fixed-priority (imp over dec) grant selection with payload mux.
REQ-030 trace_ctrl does not instantiate the trace table; connected at top level.

Verification
REQ-031 imp_req and dec_req same cycle in IDLE (imp_var=5,val=1; dec_var=9,val=0) -> imp_gnt, tt_push type1 var5; after tt_done, dec_gnt type0 var9, level 0->1.
REQ-032 Trace [D var3 val1, F var7 val0, F var8 val1], conflict -> unassign var8, var7, var3 in order, then tt_push type1 var3 val0, bt_done, level 1->0.
REQ-033 Empty trace, conflict -> single tt_pop, tt_empty=1 -> unsat=1 held; subsequent dec_req never granted.
REQ-034 Conflict during PUSH_WAIT -> push completes, backtrack starts next IDLE cycle before pending dec_req.
REQ-035 reset=0 asserted in POP_WAIT -> all outputs 0 immediately (no clock edge), state IDLE after release.
REQ-036 128 decisions pushed -> level=128; further decision push leaves level=128.
